// File: rtl/instr_fetch_decode_pkg.sv
`default_nettype none
// ============================================================================
// instr_fetch_decode_pkg : shared state encoding and instruction field layout
// Revision: 1.0
// ============================================================================
package instr_fetch_decode_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        DECODE = 3'd3,
        ISSUE  = 3'd4,
        EXEC   = 3'd5,
        HALTED = 3'd6
    } state_t;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'b1111;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int P1_MSB     = 11;
    localparam int P1_LSB     = 6;
    localparam int P2_MSB     = 5;
    localparam int P2_LSB     = 0;

    function automatic logic [3:0] get_opcode(input logic [15:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

    function automatic logic [5:0] get_p1(input logic [15:0] word);
        return word[P1_MSB:P1_LSB];
    endfunction

    function automatic logic [5:0] get_p2(input logic [15:0] word);
        return word[P2_MSB:P2_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_decode_fetch_watchdog.sv
`default_nettype none
// ============================================================================
// instr_fetch_decode_fetch_watchdog : EXEC-cycle counter with expiry flag
// Revision: 1.0
// ============================================================================
module instr_fetch_decode_fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int             CW   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST; the FSM leaves EXEC on that cycle anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign expire = enable && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// instr_fetch_decode : PC owner, ROM fetch, decode and issue to controller
// Revision: 1.0
// ============================================================================
module instr_fetch_decode
    import instr_fetch_decode_pkg::*;
#(
    parameter int         PC_WIDTH       = 8,
    parameter int         TIMEOUT_CYCLES = 64,
    parameter logic [3:0] HALT_OP        = HALT_OP_DEFAULT
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RUN,
    output logic                mem_rd,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_data,
    output logic                START,
    output logic [3:0]          OPCODE,
    output logic [5:0]          p1,
    output logic [5:0]          p2,
    input  logic                PCinc,
    input  logic                finish,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                halted,
    output logic                timeout_err
);

    state_t      state;
    logic [15:0] ir;
    logic        wd_expire;

    instr_fetch_decode_fetch_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (CLK),
        .rst_n  (RESET),
        .clear  (state == ISSUE),
        .enable (state == EXEC),
        .expire (wd_expire)
    );

    assign mem_addr = pc;
    assign OPCODE   = get_opcode(ir);
    assign p1       = get_p1(ir);
    assign p2       = get_p2(ir);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            pc          <= '0;
            ir          <= '0;
            mem_rd      <= 1'b0;
            START       <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            START  <= 1'b0;

            // PC moves only while the controller owns the instruction.
            if (PCinc && ((state == ISSUE) || (state == EXEC))) begin
                pc <= pc + PC_WIDTH'(1);
            end

            case (state)
                IDLE: begin
                    if (RUN) begin
                        state  <= FETCH;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    ir    <= mem_data;
                    state <= DECODE;
                end
                DECODE: begin
                    if (get_opcode(ir) == HALT_OP) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        state <= ISSUE;
                        START <= 1'b1;
                    end
                end
                ISSUE: begin
                    state <= EXEC;
                end
                EXEC: begin
                    // A finish on the expiry cycle still counts as success.
                    if (finish) begin
                        if (RUN) begin
                            state  <= FETCH;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (wd_expire) begin
                        state       <= HALTED;
                        halted      <= 1'b1;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_decode : directed self-checking bench for instr_fetch_decode
// Revision: 1.0
// ============================================================================
module tb_instr_fetch_decode;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        RUN = 1'b0;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data = 16'h0000;
    logic        START;
    logic [3:0]  OPCODE;
    logic [5:0]  p1;
    logic [5:0]  p2;
    logic        PCinc = 1'b0;
    logic        finish = 1'b0;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        timeout_err;

    logic [15:0] rom [0:255];
    int errors = 0;
    int checks = 0;

    instr_fetch_decode #(
        .PC_WIDTH       (8),
        .TIMEOUT_CYCLES (8),
        .HALT_OP        (4'b1111)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .RUN         (RUN),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .START       (START),
        .OPCODE      (OPCODE),
        .p1          (p1),
        .p2          (p2),
        .PCinc       (PCinc),
        .finish      (finish),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RESET = 1'b0; RUN = 1'b0; PCinc = 1'b0; finish = 1'b0;
        tick; tick;
        RESET = 1'b1;
    endtask

    task automatic wait_start;
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick;
            if (START === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_start: START=%b after 20 cycles, required 1", START);
        end
    endtask

    task automatic run_instr(input int k);
        wait_start;
        tick;
        for (int j = 1; j <= k; j++) begin
            PCinc = 1'b1;
            finish = (j == k);
            tick;
        end
        PCinc = 1'b0;
        finish = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        tick; tick;
        checks++;
        if ({START, mem_rd, busy, halted, timeout_err, OPCODE, p1, p2, pc} !== '0) begin
            errors++;
            $display("FAIL reset_state: got S%b R%b B%b H%b T%b op%h p1%h p2%h pc%h, required all 0",
                     START, mem_rd, busy, halted, timeout_err, OPCODE, p1, p2, pc);
        end
        RESET = 1'b1;
    endtask

    task automatic test_basic_issue;
        RUN = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            checks++;
            if (mem_rd !== (i == 1) || START !== (i == 4)) begin
                errors++;
                $display("FAIL issue_timing cycle %0d: mem_rd=%b START=%b, required %b %b",
                         i, mem_rd, START, (i == 1), (i == 4));
            end
        end
        checks++;
        if (OPCODE !== 4'b1000 || p1 !== 6'b000011 || p2 !== 6'b010101 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_fields: op=%b p1=%b p2=%b busy=%b, required 1000 000011 010101 1",
                     OPCODE, p1, p2, busy);
        end
    endtask

    task automatic test_pc_advance;
        tick;
        PCinc = 1'b1; tick; PCinc = 1'b0;
        checks++;
        if (pc !== 8'd1) begin
            errors++;
            $display("FAIL pcinc_exec: pc=%0d, required 1", pc);
        end
        finish = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            finish = 1'b0;
            PCinc = (i < 4);
            checks++;
            if (mem_rd !== (i == 1) || START !== (i == 4)) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: mem_rd=%b START=%b, required %b %b",
                         i, mem_rd, START, (i == 1), (i == 4));
            end
        end
        checks++;
        if (pc !== 8'd1 || OPCODE !== 4'b1001) begin
            errors++;
            $display("FAIL pcinc_ignored: pc=%0d op=%b, required 1 1001", pc, OPCODE);
        end
        finish = 1'b1; tick; finish = 1'b0; tick;
        checks++;
        if (mem_rd !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL finish_in_issue: mem_rd=%b busy=%b, required 0 1", mem_rd, busy);
        end
        PCinc = 1'b1; tick; PCinc = 1'b0; tick;
        PCinc = 1'b1; tick; PCinc = 1'b0;
        checks++;
        if (pc !== 8'd3) begin
            errors++;
            $display("FAIL multi_pcinc: pc=%0d, required 3", pc);
        end
    endtask

    task automatic test_halt;
        bit act = 1'b0;
        finish = 1'b1; tick; finish = 1'b0;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'd3) begin
            errors++;
            $display("FAIL halt_fetch: mem_rd=%b addr=%0d, required 1 3", mem_rd, mem_addr);
        end
        tick; tick; tick;
        checks++;
        if (halted !== 1'b1 || START !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL halt_state: halted=%b START=%b busy=%b to=%b, required 1 0 0 0",
                     halted, START, busy, timeout_err);
        end
        for (int i = 0; i < 6; i++) begin
            tick;
            if (mem_rd !== 1'b0 || START !== 1'b0) act = 1'b1;
        end
        checks++;
        if (act || halted !== 1'b1) begin
            errors++;
            $display("FAIL halt_sticky: activity=%b halted=%b, required 0 1", act, halted);
        end
    endtask

    task automatic test_timeout;
        do_reset;
        RUN = 1'b1;
        wait_start;
        tick;
        for (int i = 0; i < 7; i++) tick;
        checks++;
        if (halted !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early: halted=%b busy=%b after 7 EXEC cycles, required 0 1", halted, busy);
        end
        tick;
        checks++;
        if (halted !== 1'b1 || timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: halted=%b to=%b busy=%b, required 1 1 0", halted, timeout_err, busy);
        end
        finish = 1'b1; tick; finish = 1'b0; tick;
        checks++;
        if (mem_rd !== 1'b0 || START !== 1'b0 || halted !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL late_finish: mem_rd=%b START=%b halted=%b to=%b, required 0 0 1 1",
                     mem_rd, START, halted, timeout_err);
        end
    endtask

    task automatic test_finish_beats_timeout;
        do_reset;
        RUN = 1'b1;
        wait_start;
        tick;
        for (int i = 0; i < 7; i++) tick;
        finish = 1'b1; tick; finish = 1'b0;
        checks++;
        if (timeout_err !== 1'b0 || halted !== 1'b0 || mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL finish_vs_timeout: to=%b halted=%b mem_rd=%b, required 0 0 1",
                     timeout_err, halted, mem_rd);
        end
    endtask

    task automatic test_run_drop;
        bit act = 1'b0;
        wait_start;
        RUN = 1'b0;
        tick; tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL run_drop_completes: busy=%b, required 1", busy);
        end
        finish = 1'b1; tick; finish = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (mem_rd !== 1'b0 || busy !== 1'b0) act = 1'b1;
            tick;
        end
        checks++;
        if (act) begin
            errors++;
            $display("FAIL run_drop_idle: mem_rd=%b busy=%b, required 0 0", mem_rd, busy);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000;
        do_reset;
        RUN = 1'b1;
        for (int n = 0; n < 51; n++) run_instr(5);
        checks++;
        if (pc !== 8'hFF) begin
            errors++;
            $display("FAIL wrap_preset: pc=%h, required ff", pc);
        end
        run_instr(1);
        checks++;
        if (pc !== 8'h00 || mem_addr !== 8'h00 || mem_rd !== 1'b1) begin
            errors++;
            $display("FAIL wrap_simul: pc=%h addr=%h mem_rd=%b, required 00 00 1", pc, mem_addr, mem_rd);
        end
    endtask

    task automatic test_async_reset;
        wait_start;
        tick;
        PCinc = 1'b1; tick; PCinc = 1'b0;
        checks++;
        if (pc !== 8'd1 || OPCODE !== 4'b0001 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: pc=%0d op=%b busy=%b, required 1 0001 1", pc, OPCODE, busy);
        end
        #2;
        RESET = 1'b0;
        #1;
        checks++;
        if (START !== 1'b0 || OPCODE !== 4'd0 || pc !== 8'd0 || busy !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: START=%b op=%b pc=%0d busy=%b halted=%b, required all 0",
                     START, OPCODE, pc, busy, halted);
        end
        RESET = 1'b1;
        tick;
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'd0) begin
            errors++;
            $display("FAIL restart_fetch: mem_rd=%b addr=%0d, required 1 0", mem_rd, mem_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h1000;
        rom[0] = 16'h80D5;
        rom[1] = 16'h9000;
        rom[2] = 16'h2000;
        rom[3] = 16'hF000;
        test_reset;
        test_basic_issue;
        test_pc_advance;
        test_halt;
        test_timeout;
        test_finish_beats_timeout;
        test_run_drop;
        test_wrap;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
